// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V style control FSM: fetch/decode/exec/mem/writeback sequencing,
// registered datapath controls, memory wait timeout and a saturating retire counter.
module multicycle_control_unit #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter bit HALT_ON_SYSTEM = 1'b1,
   parameter int RET_W          = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       Opcode,
   input  logic [2:0]       Funct3,
   input  logic             mem_ready,
   input  logic             branch_taken,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             ir_load,
   output logic             pc_write,
   output logic             RegWrite,
   output logic [1:0]       ALUOp,
   output logic             ALUSrc,
   output logic             AUIPC_Sel,
   output logic [1:0]       PC_Sel,
   output logic [1:0]       writeData_Sel,
   output logic [2:0]       state,
   output logic             halted,
   output logic             fault,
   output logic [RET_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_FAULT  = 3'd6
   } state_t;

   localparam logic [4:0] OP_LOAD    = 5'b00000;
   localparam logic [4:0] OP_ARITH_I = 5'b00100;
   localparam logic [4:0] OP_AUIPC   = 5'b00101;
   localparam logic [4:0] OP_STORE   = 5'b01000;
   localparam logic [4:0] OP_ARITH_R = 5'b01100;
   localparam logic [4:0] OP_LUI     = 5'b01101;
   localparam logic [4:0] OP_NOP     = 5'b10001;
   localparam logic [4:0] OP_BRANCH  = 5'b11000;
   localparam logic [4:0] OP_JALR    = 5'b11001;
   localparam logic [4:0] OP_JAL     = 5'b11011;
   localparam logic [4:0] OP_SYSTEM  = 5'b11100;

   localparam int WAIT_W  = $clog2(TIMEOUT_CYCLES + 2);
   localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam bit TO_EN   = (TIMEOUT_CYCLES > 0);

   state_t            state_q, state_d;
   logic [1:0]        alu_op_q, pc_sel_q, wd_sel_q;
   logic              alu_src_q, auipc_q;
   logic              op_load_q, op_store_q, op_branch_q, op_nop_q;
   logic [WAIT_W-1:0] wait_q;
   logic [RET_W-1:0]  retired_q;

   logic [1:0] d_alu_op, d_pc_sel, d_wd_sel;
   logic       d_alu_src, d_auipc, d_load, d_store, d_branch, d_nop;
   state_t     d_next;
   logic       timeout_hit, retire;
   logic       funct3_unused;

   // Funct3 is carried on the interface for future decode refinement only.
   assign funct3_unused = ^Funct3;

   always_comb begin
      d_alu_op  = 2'b00;
      d_pc_sel  = 2'b00;
      d_wd_sel  = 2'b00;
      d_alu_src = 1'b0;
      d_auipc   = 1'b0;
      d_load    = 1'b0;
      d_store   = 1'b0;
      d_branch  = 1'b0;
      d_nop     = 1'b0;
      d_next    = S_EXEC;
      case (Opcode)
         OP_BRANCH:  begin d_alu_op = 2'b01; d_pc_sel = 2'b01; d_branch = 1'b1; end
         OP_LOAD:    begin d_alu_src = 1'b1; d_wd_sel = 2'b01; d_load = 1'b1; end
         OP_STORE:   begin d_alu_src = 1'b1; d_store = 1'b1; end
         OP_JALR:    begin d_alu_src = 1'b1; d_wd_sel = 2'b10; d_pc_sel = 2'b10; end
         OP_JAL:     begin d_alu_src = 1'b1; d_wd_sel = 2'b10; d_pc_sel = 2'b01; end
         OP_ARITH_I: begin d_alu_op = 2'b10; d_alu_src = 1'b1; end
         OP_ARITH_R: begin d_alu_op = 2'b10; end
         OP_AUIPC:   begin d_alu_src = 1'b1; d_auipc = 1'b1; end
         OP_LUI:     begin d_alu_op = 2'b11; d_alu_src = 1'b1; end
         OP_NOP:     begin d_nop = 1'b1; d_next = S_WB; end
         OP_SYSTEM: begin
            if (HALT_ON_SYSTEM) begin
               d_next = S_HALT;
            end else begin
               d_nop  = 1'b1;
               d_next = S_WB;
            end
         end
         default:    d_next = S_FAULT;
      endcase
   end

   // A mem_ready in the final allowed cycle takes priority over the timeout.
   assign timeout_hit = TO_EN && !mem_ready && (wait_q == WAIT_W'(TO_LAST));

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
                   else if (timeout_hit) state_d = S_FAULT;
         S_DECODE: state_d = d_next;
         S_EXEC:   if (op_load_q || op_store_q) state_d = S_MEM;
                   else if (op_branch_q) state_d = S_FETCH;
                   else state_d = S_WB;
         S_MEM:    if (mem_ready) state_d = op_load_q ? S_WB : S_FETCH;
                   else if (timeout_hit) state_d = S_FAULT;
         S_WB:     state_d = S_FETCH;
         default:  state_d = state_q;
      endcase
   end

   assign retire = (state_q == S_WB)
                || (state_q == S_EXEC && op_branch_q)
                || (state_q == S_MEM && op_store_q && mem_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_FETCH;
         alu_op_q    <= 2'b00;
         pc_sel_q    <= 2'b00;
         wd_sel_q    <= 2'b00;
         alu_src_q   <= 1'b0;
         auipc_q     <= 1'b0;
         op_load_q   <= 1'b0;
         op_store_q  <= 1'b0;
         op_branch_q <= 1'b0;
         op_nop_q    <= 1'b0;
         wait_q      <= '0;
         retired_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) begin
            alu_op_q    <= d_alu_op;
            pc_sel_q    <= d_pc_sel;
            wd_sel_q    <= d_wd_sel;
            alu_src_q   <= d_alu_src;
            auipc_q     <= d_auipc;
            op_load_q   <= d_load;
            op_store_q  <= d_store;
            op_branch_q <= d_branch;
            op_nop_q    <= d_nop;
         end
         if (state_d != state_q) begin
            wait_q <= '0;
         end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready && wait_q != '1) begin
            wait_q <= wait_q + WAIT_W'(1);
         end
         if (retire && retired_q != '1) begin
            retired_q <= retired_q + RET_W'(1);
         end
      end
   end

   // Strobes are forced low while reset is asserted, not just after the next edge.
   always_comb begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      ir_load  = 1'b0;
      pc_write = 1'b0;
      RegWrite = 1'b0;
      if (rst_n) begin
         case (state_q)
            S_FETCH: begin
               mem_req = 1'b1;
               ir_load = mem_ready;
            end
            S_EXEC:  pc_write = op_branch_q;
            S_MEM: begin
               mem_req  = 1'b1;
               addr_sel = 1'b1;
               mem_we   = op_store_q;
               pc_write = op_store_q && mem_ready;
            end
            S_WB: begin
               pc_write = 1'b1;
               RegWrite = !op_nop_q;
            end
            default: ;
         endcase
      end
   end

   assign PC_Sel        = (state_q == S_EXEC && op_branch_q) ? (branch_taken ? 2'b01 : 2'b00)
                                                             : pc_sel_q;
   assign ALUOp         = alu_op_q;
   assign ALUSrc        = alu_src_q;
   assign AUIPC_Sel     = auipc_q;
   assign writeData_Sel = wd_sel_q;
   assign state         = state_q;
   assign halted        = (state_q == S_HALT);
   assign fault         = (state_q == S_FAULT);
   assign retired       = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: default instance plus a small
// instance (TIMEOUT_CYCLES=4, HALT_ON_SYSTEM=0, RET_W=2).
module tb_multicycle_control_unit;

   logic       clk = 1'b0;
   logic       rst_n, rst2_n;
   logic [4:0] opcode;
   logic [2:0] funct3;
   logic       mem_ready, branch_taken;

   logic        a_mem_req, a_mem_we, a_addr_sel, a_ir_load, a_pc_write, a_reg_write;
   logic [1:0]  a_alu_op, a_pc_sel, a_wd_sel;
   logic        a_alu_src, a_auipc_sel, a_halted, a_fault;
   logic [2:0]  a_state;
   logic [31:0] a_retired;

   logic        b_mem_req, b_mem_we, b_addr_sel, b_ir_load, b_pc_write, b_reg_write;
   logic [1:0]  b_alu_op, b_pc_sel, b_wd_sel;
   logic        b_alu_src, b_auipc_sel, b_halted, b_fault;
   logic [2:0]  b_state;
   logic [1:0]  b_retired;

   int errors = 0;
   int checks = 0;

   localparam logic [4:0] LOAD = 5'b00000, STORE = 5'b01000, ARITH_R = 5'b01100;
   localparam logic [4:0] BRANCH = 5'b11000, JAL = 5'b11011, NOP = 5'b10001;
   localparam logic [4:0] SYS = 5'b11100, BAD = 5'b11111;

   always #5 clk = ~clk;

   multicycle_control_unit dut (
      .clk(clk), .rst_n(rst_n), .Opcode(opcode), .Funct3(funct3),
      .mem_ready(mem_ready), .branch_taken(branch_taken),
      .mem_req(a_mem_req), .mem_we(a_mem_we), .addr_sel(a_addr_sel), .ir_load(a_ir_load),
      .pc_write(a_pc_write), .RegWrite(a_reg_write), .ALUOp(a_alu_op), .ALUSrc(a_alu_src),
      .AUIPC_Sel(a_auipc_sel), .PC_Sel(a_pc_sel), .writeData_Sel(a_wd_sel), .state(a_state),
      .halted(a_halted), .fault(a_fault), .retired(a_retired)
   );

   multicycle_control_unit #(.TIMEOUT_CYCLES(4), .HALT_ON_SYSTEM(1'b0), .RET_W(2)) dut2 (
      .clk(clk), .rst_n(rst2_n), .Opcode(opcode), .Funct3(funct3),
      .mem_ready(mem_ready), .branch_taken(branch_taken),
      .mem_req(b_mem_req), .mem_we(b_mem_we), .addr_sel(b_addr_sel), .ir_load(b_ir_load),
      .pc_write(b_pc_write), .RegWrite(b_reg_write), .ALUOp(b_alu_op), .ALUSrc(b_alu_src),
      .AUIPC_Sel(b_auipc_sel), .PC_Sel(b_pc_sel), .writeData_Sel(b_wd_sel), .state(b_state),
      .halted(b_halted), .fault(b_fault), .retired(b_retired)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, then drive this cycle's inputs and let outputs settle.
   task automatic nc(input logic r, input logic [4:0] op, input logic bt);
      @(posedge clk);
      #1;
      mem_ready    = r;
      opcode       = op;
      branch_taken = bt;
      #1;
   endtask

   initial begin
      rst_n = 1'b0; rst2_n = 1'b0;
      opcode = 5'b0; funct3 = 3'b0; mem_ready = 1'b0; branch_taken = 1'b0;
      #3;
      chk("rst_state", a_state, 0);
      chk("rst_mem_req", a_mem_req, 0);
      chk("rst_retired", a_retired, 0);
      chk("rst_ctrl", {a_alu_op, a_pc_sel, a_wd_sel, a_alu_src, a_auipc_sel, a_halted, a_fault}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1; mem_ready = 1'b1; opcode = ARITH_R; #1;

      // Arith_R, no waits
      chk("r_fetch_req", {a_state, a_mem_req, a_addr_sel, a_ir_load}, {3'd0, 3'b101});
      nc(1, ARITH_R, 0); chk("r_decode", {a_state, a_mem_req, a_pc_write, a_reg_write, a_ir_load}, {3'd1, 4'b0000});
      nc(1, ARITH_R, 0); chk("r_exec", {a_state, a_alu_op, a_alu_src}, {3'd2, 2'b10, 1'b0});
      nc(1, ARITH_R, 0); chk("r_wb", {a_state, a_reg_write, a_pc_write, a_wd_sel}, {3'd4, 2'b11, 2'b00});
      nc(1, LOAD, 0);    chk("r_done", {a_state, a_retired[3:0]}, {3'd0, 4'd1});

      // Load with 3 data wait cycles
      nc(1, LOAD, 0); chk("ld_decode", a_state, 1);
      nc(1, LOAD, 0); chk("ld_exec", {a_state, a_alu_src, a_alu_op}, {3'd2, 1'b1, 2'b00});
      for (int i = 0; i < 4; i++) begin
         nc((i == 3), LOAD, 0);
         chk("ld_mem", {a_state, a_mem_req, a_addr_sel, a_mem_we, a_pc_write}, {3'd3, 4'b1100});
      end
      nc(1, BRANCH, 0); chk("ld_wb", {a_state, a_wd_sel, a_reg_write}, {3'd4, 2'b01, 1'b1});
      nc(1, BRANCH, 0); chk("ld_done", {a_state, a_retired[3:0]}, {3'd0, 4'd2});

      // Branch taken then not taken
      nc(1, BRANCH, 0); chk("bt_decode", a_state, 1);
      nc(1, BRANCH, 1); chk("bt_exec", {a_state, a_pc_write, a_pc_sel, a_reg_write}, {3'd2, 1'b1, 2'b01, 1'b0});
      nc(1, BRANCH, 0); chk("bt_done", {a_state, a_retired[3:0]}, {3'd0, 4'd3});
      nc(1, BRANCH, 0);
      nc(1, BRANCH, 0); chk("bn_exec", {a_state, a_pc_write, a_pc_sel, a_reg_write}, {3'd2, 1'b1, 2'b00, 1'b0});
      nc(1, STORE, 0);  chk("bn_done", {a_state, a_retired[3:0]}, {3'd0, 4'd4});

      // Store, immediate ready in MEM
      nc(1, STORE, 0);
      nc(1, STORE, 0);
      nc(1, STORE, 0); chk("st_mem", {a_state, a_mem_req, a_addr_sel, a_mem_we, a_pc_write, a_pc_sel, a_reg_write},
                           {3'd3, 4'b1111, 2'b00, 1'b0});
      nc(1, JAL, 0);   chk("st_done", {a_state, a_retired[3:0]}, {3'd0, 4'd5});

      // JAL
      nc(1, JAL, 0);
      nc(1, JAL, 0); chk("jal_exec", {a_state, a_alu_src, a_wd_sel, a_pc_sel}, {3'd2, 1'b1, 2'b10, 2'b01});
      nc(1, JAL, 0); chk("jal_wb", {a_state, a_reg_write, a_pc_write}, {3'd4, 2'b11});
      nc(1, NOP, 0); chk("jal_done", a_retired, 6);

      // NOP skips EXEC, no RegWrite
      nc(1, NOP, 0); chk("nop_decode", a_state, 1);
      nc(1, NOP, 0); chk("nop_wb", {a_state, a_reg_write, a_pc_write, a_pc_sel}, {3'd4, 2'b01, 2'b00});
      nc(1, LOAD, 0); chk("nop_done", {a_state, a_retired[3:0]}, {3'd0, 4'd7});

      // Asynchronous reset in the middle of a data access
      nc(1, LOAD, 0);
      nc(1, LOAD, 0);
      nc(0, LOAD, 0); chk("mr_mem", {a_state, a_mem_req}, {3'd3, 1'b1});
      #2 rst_n = 1'b0; #1;
      chk("mr_async", {a_state, a_mem_req, a_pc_write, a_reg_write, a_alu_src, a_wd_sel}, 0);
      chk("mr_retired", a_retired, 0);
      @(posedge clk); #1;
      rst_n = 1'b1; mem_ready = 1'b1; opcode = SYS; #1;

      // SYSTEM halts on the default instance
      chk("sys_fetch", {a_state, a_mem_req}, {3'd0, 1'b1});
      nc(1, SYS, 0); chk("sys_decode", a_state, 1);
      nc(1, SYS, 0); chk("sys_halt", {a_state, a_halted, a_mem_req, a_fault}, {3'd5, 1'b1, 2'b00});
      nc(1, SYS, 0); chk("sys_hold", {a_state, a_halted, a_mem_req, a_pc_write}, {3'd5, 1'b1, 2'b00});

      // Unlisted opcode faults
      #2 rst_n = 1'b0; #1;
      chk("halt_cleared", {a_state, a_halted}, {3'd0, 1'b0});
      @(posedge clk); #1;
      rst_n = 1'b1; mem_ready = 1'b1; opcode = BAD; #1;
      nc(1, BAD, 0);
      nc(1, BAD, 0); chk("bad_fault", {a_state, a_fault, a_mem_req, a_halted}, {3'd6, 1'b1, 2'b00});
      nc(1, BAD, 0); chk("bad_hold", {a_state, a_fault, a_mem_req}, {3'd6, 1'b1, 1'b0});

      // Small instance: fetch timeout after 4 wait cycles
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst2_n = 1'b1; mem_ready = 1'b0; opcode = SYS; #1;
      chk("to_w1", {b_state, b_mem_req}, {3'd0, 1'b1});
      for (int i = 0; i < 3; i++) begin
         nc(0, SYS, 0); chk("to_wait", {b_state, b_mem_req, b_fault}, {3'd0, 2'b10});
      end
      nc(0, SYS, 0); chk("to_fault", {b_state, b_fault, b_mem_req}, {3'd6, 1'b1, 1'b0});
      nc(1, SYS, 0); chk("to_hold", {b_state, b_fault, b_mem_req}, {3'd6, 1'b1, 1'b0});

      // Ready in the 4th wait cycle wins over the timeout
      #2 rst2_n = 1'b0; #1;
      chk("to_rst", {b_state, b_fault}, 0);
      @(posedge clk); #1;
      rst2_n = 1'b1; mem_ready = 1'b0; #1;
      nc(0, SYS, 0);
      nc(0, SYS, 0);
      nc(1, SYS, 0); chk("edge_c4", {b_state, b_ir_load, b_fault}, {3'd0, 2'b10});
      nc(1, SYS, 0); chk("edge_decode", {b_state, b_fault}, {3'd1, 1'b0});
      nc(1, NOP, 0); chk("sysnop_wb", {b_state, b_reg_write, b_pc_write, b_halted}, {3'd4, 3'b010});
      nc(1, NOP, 0); chk("sysnop_done", {b_state, b_retired}, {3'd0, 2'd1});

      // Four NOPs: retired saturates at 3 with RET_W=2
      for (int n = 0; n < 4; n++) begin
         nc(1, NOP, 0);
         nc(1, NOP, 0);
         nc(1, NOP, 0);
         if (n == 1) chk("ret_at_3", b_retired, 3);
      end
      chk("ret_sat", {b_state, b_retired}, {3'd0, 2'd3});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
